// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX among NUM_REQ byte requesters.
// Latches the winner's byte and parity config and holds it until the frame ends.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_par_en,
    input  logic [NUM_REQ-1:0]         req_par_type,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_busy,
    output logic                       tx_data_valid,
    output logic [7:0]                 tx_p_data,
    output logic                       tx_parity_enable,
    output logic                       tx_parity_type,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       frame_done,
    output logic                       tx_error
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_en_q, par_en_d;
    logic          par_type_q, par_type_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [NUM_REQ-1:0] rot;
    logic [IW:0]        sum;
    logic               found;
    logic [IW-1:0]      sel;
    logic [7:0]         sel_data;
    logic               sel_pe;
    logic               sel_pt;

    // Rotate so bit 0 is rr_ptr; first set bit is the winner's offset.
    always_comb begin
        rot   = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr_q} + (IW+1)'(i);
            end
        end
        if (sum >= (IW+1)'(NUM_REQ)) begin
            sel = IW'(sum - (IW+1)'(NUM_REQ));
        end else begin
            sel = IW'(sum);
        end
    end

    always_comb begin
        sel_data = '0;
        sel_pe   = 1'b0;
        sel_pt   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IW'(i)) begin
                sel_data = req_data[8*i +: 8];
                sel_pe   = req_par_en[i];
                sel_pt   = req_par_type[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        active_d   = active_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!tx_busy && found) begin
                    grant_d    = sel;
                    data_d     = sel_data;
                    par_en_d   = sel_pe;
                    par_type_d = sel_pt;
                    active_d   = 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                if (grant_q == IW'(NUM_REQ-1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_q + 1'b1;
                end
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == 4'(BUSY_TIMEOUT)) begin
                        err_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            active_q   <= active_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tx_data_valid    = (state_q == LAUNCH);
    assign req_ready        = tx_data_valid ? (NUM_REQ'(1) << grant_q) : '0;
    assign tx_p_data        = data_q;
    assign tx_parity_enable = par_en_q;
    assign tx_parity_type   = par_type_q;
    assign grant_id         = grant_q;
    assign active           = active_q;
    assign frame_done       = done_q;
    assign tx_error         = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level scheduling model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int T  = 4;
    localparam int IW = $clog2(N);

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_par_en = '0;
    logic [N-1:0]    req_par_type = '0;
    logic [N-1:0]    req_ready;
    logic            tx_busy = 1'b0;
    logic            tx_data_valid;
    logic [7:0]      tx_p_data;
    logic            tx_parity_enable;
    logic            tx_parity_type;
    logic [IW-1:0]   grant_id;
    logic            active;
    logic            frame_done;
    logic            tx_error;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(T)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_par_en       (req_par_en),
        .req_par_type     (req_par_type),
        .req_ready        (req_ready),
        .tx_busy          (tx_busy),
        .tx_data_valid    (tx_data_valid),
        .tx_p_data        (tx_p_data),
        .tx_parity_enable (tx_parity_enable),
        .tx_parity_type   (tx_parity_type),
        .grant_id         (grant_id),
        .active           (active),
        .frame_done       (frame_done),
        .tx_error         (tx_error)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // Pending bytes per requester: {data, par_en, par_type}
    logic [9:0] q[N][$];
    int len_q[$];
    int uart_len = 3;
    bit force_busy = 0;

    // Scheduling model: last served, frame launch/end cycles, latched config
    int m_last, m_gid, m_L, m_end, m_len, m_kind;
    logic [9:0] m_cfg;

    logic [9:0] log_cfg[$];
    int log_gid[$];
    int log_cyc[$];
    int err_cyc = 0;

    typedef struct {
        int         req;
        logic [7:0] data;
        logic       pe;
        logic       pt;
        int         len;
        logic [N-1:0] exp_ready;
        int         exp_gid;
        int         exp_lat;
        logic       exp_err;
    } vec_t;

    vec_t tbl[5];
    logic [7:0] exp_cont[5];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h",
                      name, cyc, act, exp);
    endtask

    function automatic logic [31:0] act_vec();
        return 32'({tx_data_valid, req_ready, frame_done, tx_error, active,
                    grant_id, tx_p_data, tx_parity_enable, tx_parity_type});
    endfunction

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_gid  = 0;
        m_L    = -100;
        m_end  = 0;
        m_len  = 0;
        m_kind = 0;
        m_cfg  = '0;
        for (int i = 0; i < N; i++) q[i].delete();
        len_q.delete();
        force_busy = 0;
    endtask

    task automatic clear_log();
        log_cfg.delete();
        log_gid.delete();
        log_cyc.delete();
    endtask

    task automatic step();
        logic [N-1:0] v;
        logic b, dv_e, done_e, err_e, act_e;
        logic [N-1:0] rdy_e;
        int g;
        @(negedge CLK);
        cyc++;
        dv_e   = (cyc == m_L);
        rdy_e  = dv_e ? (N'(1) << m_gid) : '0;
        done_e = (cyc == m_end) && (m_kind == 1);
        err_e  = (cyc == m_end) && (m_kind == 2);
        act_e  = (cyc >= m_L) && (cyc < m_end);
        check("cycle", act_vec(),
              32'({dv_e, rdy_e, done_e, err_e, act_e, IW'(m_gid), m_cfg}));
        if (tx_data_valid) begin
            log_cfg.push_back({tx_p_data, tx_parity_enable, tx_parity_type});
            log_gid.push_back(int'(grant_id));
            log_cyc.push_back(cyc);
        end
        if (tx_error) err_cyc = cyc;
        // UART raises busy the cycle after Data_Valid, for m_len cycles
        b = force_busy || (m_len > 0 && cyc > m_L && cyc <= m_L + m_len);
        for (int i = 0; i < N; i++) begin
            v[i] = (q[i].size() > 0);
            if (v[i])
                {req_data[8*i +: 8], req_par_en[i], req_par_type[i]} = q[i][0];
            else
                {req_data[8*i +: 8], req_par_en[i], req_par_type[i]} = 10'($urandom);
        end
        req_valid = v;
        tx_busy   = b;
        if (cyc >= m_end && !b && v != '0) begin
            g = -1;
            for (int k = 1; k <= N; k++)
                if (g < 0 && v[IW'((m_last + k) % N)]) g = (m_last + k) % N;
            m_gid  = g;
            m_last = g;
            m_cfg  = q[g].pop_front();
            m_L    = cyc + 1;
            m_len  = (len_q.size() > 0) ? len_q.pop_front() : uart_len;
            if (m_len > 0) begin
                m_end  = m_L + m_len + 2;
                m_kind = 1;
            end else begin
                m_end  = m_L + 1 + T;
                m_kind = 2;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (n < 300 && (pending() || cyc < m_end)) begin
            step();
            n++;
        end
        step();
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        check("reset_outputs", act_vec(), 32'd0);
        req_valid = '0;
        tx_busy   = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        int n;
        int rel;
        bit seen;
        tbl[0] = '{2, 8'hA5, 1'b1, 1'b1, 11, 4'b0100, 2, 13, 1'b0};
        tbl[1] = '{0, 8'h3C, 1'b0, 1'b0,  3, 4'b0001, 0,  5, 1'b0};
        tbl[2] = '{3, 8'hFF, 1'b1, 1'b0,  1, 4'b1000, 3,  3, 1'b0};
        tbl[3] = '{1, 8'h00, 1'b0, 1'b1,  0, 4'b0010, 1,  5, 1'b1};
        tbl[4] = '{2, 8'h5A, 1'b0, 1'b1, 11, 4'b0100, 2, 13, 1'b0};
        exp_cont = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        #3;
        do_reset();

        for (int k = 0; k < 5; k++) begin
            q[tbl[k].req].push_back({tbl[k].data, tbl[k].pe, tbl[k].pt});
            uart_len = tbl[k].len;
            seen = 0;
            n = 0;
            while (!seen && n < 10) begin
                step();
                seen = tx_data_valid;
                n++;
            end
            check("tbl_launch", 32'(seen), 32'd1);
            check("tbl_ready", 32'(req_ready), 32'(tbl[k].exp_ready));
            check("tbl_gid", 32'(grant_id), 32'(tbl[k].exp_gid));
            check("tbl_cfg", 32'({tx_p_data, tx_parity_enable, tx_parity_type}),
                  32'({tbl[k].data, tbl[k].pe, tbl[k].pt}));
            n = 0;
            seen = 0;
            while (!seen && n < 40) begin
                step();
                n++;
                seen = frame_done || tx_error;
            end
            check("tbl_latency", 32'(n), 32'(tbl[k].exp_lat));
            check("tbl_error", 32'(tx_error), 32'(tbl[k].exp_err));
            step();
        end

        // All four continuously valid from a fresh pointer
        do_reset();
        clear_log();
        uart_len = 2;
        for (int i = 0; i < N; i++) q[i].push_back({8'h10 + 8'(i), 2'b00});
        q[0].push_back({8'h10, 2'b00});
        drain();
        check("cont_count", 32'(log_gid.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_gid.size()) begin
                check("cont_data", 32'(log_cfg[i][9:2]), 32'(exp_cont[i]));
                check("cont_gid", 32'(log_gid[i]), 32'(i % N));
            end
        end

        // Serve 1, then 1 and 3 together: 3 must win
        q[1].push_back({8'h21, 2'b10});
        drain();
        clear_log();
        q[1].push_back({8'h31, 2'b11});
        q[3].push_back({8'h33, 2'b01});
        drain();
        check("rr_count", 32'(log_gid.size()), 32'd2);
        if (log_gid.size() == 2) begin
            check("rr_first", 32'(log_gid[0]), 32'd3);
            check("rr_second", 32'(log_gid[1]), 32'd1);
        end

        // UART never accepts: timeout, then next request right after
        clear_log();
        len_q.push_back(0);
        uart_len = 3;
        q[2].push_back({8'h42, 2'b00});
        q[0].push_back({8'h40, 2'b00});
        drain();
        check("to_count", 32'(log_gid.size()), 32'd2);
        if (log_gid.size() == 2) begin
            check("to_first", 32'(log_gid[0]), 32'd2);
            check("to_second", 32'(log_gid[1]), 32'd0);
            check("to_err_cyc", 32'(err_cyc), 32'(log_cyc[0] + 1 + T));
            check("to_regrant", 32'(log_cyc[1]), 32'(err_cyc + 1));
        end

        // Busy held externally blocks the grant
        clear_log();
        force_busy = 1;
        q[0].push_back({8'h50, 2'b01});
        repeat (6) step();
        check("busy_block", 32'(log_gid.size()), 32'd0);
        force_busy = 0;
        rel = cyc + 1;
        drain();
        check("busy_count", 32'(log_cyc.size()), 32'd1);
        if (log_cyc.size() == 1)
            check("busy_release", 32'(log_cyc[0]), 32'(rel + 1));

        // Reset during WAIT_DONE, then pointer restarts at 0
        q[1].push_back({8'h61, 2'b11});
        uart_len = 10;
        seen = 0;
        n = 0;
        while (!seen && n < 10) begin
            step();
            seen = tx_data_valid;
            n++;
        end
        repeat (3) step();
        check("mid_active", 32'(active), 32'd1);
        #2;
        do_reset();
        clear_log();
        uart_len = 2;
        q[2].push_back({8'h72, 2'b00});
        q[0].push_back({8'h70, 2'b00});
        drain();
        check("rst_count", 32'(log_gid.size()), 32'd2);
        if (log_gid.size() == 2)
            check("rst_first", 32'(log_gid[0]), 32'd0);

        // Random traffic
        for (int r = 0; r < 1500; r++) begin
            int rq;
            if ($urandom_range(3) == 0) begin
                rq = int'($urandom_range(N - 1));
                if (q[rq].size() < 3) q[rq].push_back(10'($urandom));
            end
            uart_len = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1));
            if (force_busy) begin
                if ($urandom_range(3) == 0) force_busy = 0;
            end else if (cyc + 1 >= m_end && $urandom_range(29) == 0) begin
                force_busy = 1;
            end
            step();
        end
        force_busy = 0;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter among NUM_REQ byte requesters. It sits between the requesters and the UART_TX datapath. It latches one requester's byte and parity configuration, launches the frame with a single-cycle Data_Valid pulse, and holds the configuration stable until the transmitter drops busy. It reports frame completion, and reports a timeout if the transmitter never accepts the frame.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after launch before flagging an error (1..15)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte available; held until matching req_ready
req_data  input  8*NUM_REQ  per-requester byte, requester i at bits [8i+7:8i]
req_par_en  input  NUM_REQ  per-requester parity enable
req_par_type  input  NUM_REQ  per-requester parity type (0 even, 1 odd)
req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester
tx_busy  input  1  busy from UART_TX
tx_data_valid  output  1  Data_Valid to UART_TX
tx_p_data  output  8  P_DATA to UART_TX
tx_parity_enable  output  1  parity_enable to UART_TX
tx_parity_type  output  1  parity_type to UART_TX
grant_id  output  clog2(NUM_REQ)  index of the requester owning the current/last frame
active  output  1  high from grant until frame completion or timeout
frame_done  output  1  one-cycle pulse when the transmitter finishes a frame
tx_error  output  1  one-cycle pulse on busy timeout

Behaviour:
- Reset (RST=0, async): state IDLE; rr_ptr=0; all outputs 0, including tx_p_data=0 and grant_id=0; timeout counter cleared. A reset mid-frame drops tx_data_valid and the config outputs immediately; the partially sent frame is abandoned.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and any req_valid=1, select the first set bit at or after rr_ptr, with wrap-around.
  - Register req_data, req_par_en and req_par_type of the selected requester into tx_p_data, tx_parity_enable and tx_parity_type; set grant_id and active=1; go to LAUNCH.
  - If tx_busy=1, no grant is made.
- LAUNCH (exactly 1 cycle):
  - tx_data_valid=1 and req_ready[grant_id]=1.
  - rr_ptr <= grant_id+1 modulo NUM_REQ.
  - Clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, pulse tx_error, set active=0 and go to IDLE.
- WAIT_DONE: on tx_busy=0, pulse frame_done, set active=0 and go to IDLE.
- tx_p_data, tx_parity_enable and tx_parity_type are stable from LAUNCH until leaving WAIT_DONE or WAIT_BUSY. They keep their last values in IDLE and change only at a new grant.
- Latency: req_valid seen in IDLE at cycle n gives tx_data_valid and req_ready at cycle n+1. The earliest next grant is the cycle after frame_done, so there is at most one frame in flight.
- Fairness: after requester k is served, requester k has the lowest priority. With all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0.
- A requester dropping req_valid after grant but before req_ready has no effect; the latched byte is still sent.
- req_valid changing in non-IDLE states is ignored.
- frame_done and tx_error are mutually exclusive and never asserted in the same cycle as tx_data_valid.

Test Plan:
- Single requester: req_valid[2]=1, req_data byte2=0xA5, par_en=1, type=1; UART model raises busy 1 cycle after Data_Valid for 11 cycles -> tx_data_valid pulse with tx_p_data=0xA5, req_ready=4'b0100 same cycle, grant_id=2, parity outputs 1/1 held until frame_done pulses the cycle after busy falls.
- All four valid continuously, bytes 0x10..0x13 -> frames sent in order 0x10,0x11,0x12,0x13,0x10; each req_ready pulses exactly once per frame.
- Requesters 1 and 3 valid with rr_ptr=2 (after serving 1) -> requester 3 granted first, then 1.
- UART model never asserts busy -> tx_error pulses BUSY_TIMEOUT=4 cycles after WAIT_BUSY entry, active falls, and the next pending request is granted in the following IDLE cycle.
- tx_busy held high externally while req_valid[0]=1 -> no grant and no tx_data_valid until busy falls, then launch the next cycle.
- Assert RST low during WAIT_DONE -> all outputs 0 asynchronously; after release, rr_ptr=0 and a request from requester 0 is granted first.
